hilo_divider: RTL
=================

# hilo_divider

HI/LO register block with an iterative 32-bit divider, sitting directly downstream of the ALU in the MIPS datapath. It captures the ALU's 64-bit product (`hi` plus the low product word) on multiply instructions. It performs signed and unsigned division over 32 iterations, writing quotient to LO and remainder to HI. It serves `mfhi`/`mflo`/`mthi`/`mtlo`, and raises `busy` so the controller stalls the pipeline until a division finishes.

## Interface
- `WIDTH`, 32, operand/register width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `a`  in  WIDTH  dividend / `mthi`/`mtlo` source (rs).
- `b`  in  WIDTH  divisor (rt).
- `prod_hi`  in  WIDTH  upper product word from the ALU.
- `prod_lo`  in  WIDTH  lower product word from the ALU.
- `mult_we`  in  1  load `{HI,LO} <= {prod_hi,prod_lo}`.
- `div_start`  in  1  begin a division of `a` by `b`.
- `div_signed`  in  1  qualifies `div_start`: 1 = `div`, 0 = `divu`.
- `mthi`  in  1  `HI <= a`.
- `mtlo`  in  1  `LO <= a`.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  division in progress; the controller must stall.
- `done`  out  1  one-cycle pulse after HI/LO receive a division result.

## Operation
- State machine: IDLE, RUN, FINISH.
- IDLE:
  - Commands are accepted with priority `div_start` > `mult_we` > (`mthi`, `mtlo`).
  - `mthi` and `mtlo` asserted together both apply.
  - Lower-priority commands in the same cycle are dropped.
- `div_start` in IDLE latches the operands:
  - Signed mode: latch `|a|` and `|b|` (two's-complement magnitude; `0x80000000` becomes magnitude `2^31`, unsigned).
  - Unsigned mode: latch raw `a` and `b`.
  - Record `neg_q = div_signed & (a[31]^b[31])` and `neg_r = div_signed & a[31]`.
  - Clear the WIDTH+1-bit partial remainder and the iteration counter; go to RUN.
- RUN, each cycle (restoring division):
  - Shift `{rem, quot}` left one bit.
  - Trial-subtract the divisor magnitude from `rem`.
  - If non-negative, keep the difference and set `quot[0] = 1`.
  - The counter counts 0 to WIDTH-1; after the WIDTH-th iteration, go to FINISH.
- FINISH:
  - `LO <= neg_q ? -quot : quot` and `HI <= neg_r ? -rem : rem`.
  - Set `done`; go to IDLE.
- Divide by zero falls out of the algorithm and is required behaviour:
  - Unsigned: `LO = 0xFFFFFFFF`, `HI = a`.
  - Signed: quotient and remainder are computed on magnitudes, then the sign fix is applied unchanged.
- Overflow, `0x80000000 / 0xFFFFFFFF` signed: `LO = 0x80000000`, `HI = 0`. No trap.
- While `busy`:
  - `div_start`, `mult_we`, `mthi` and `mtlo` are ignored.
  - HI and LO hold their previous values until FINISH.
- Quotient sign follows the dividend and divisor signs; the remainder takes the sign of the dividend (truncating division).

## Timing
- Reset (asynchronous, immediate): state = IDLE, `hi = 0`, `lo = 0`, `busy = 0`, `done = 0`, counter and operand registers = 0.
- Reset asserted mid-division aborts it; no partial result reaches HI or LO.
- `mult_we`, `mthi` and `mtlo` take effect at the edge where they are sampled; the new value is visible on `hi`/`lo` the following cycle.
- Division latency, with `div_start` sampled at edge E0:
  - E1–E32: RUN iterations.
  - E33: FINISH; HI and LO are written.
- `busy` is combinational (`state != IDLE`): high from after E0 until after E33, i.e. 33 cycles.
- `done` is registered: high for exactly the one cycle following E33; `busy` is already low in that cycle.
- A new `div_start` is accepted in the same cycle `done` is high; back-to-back divisions therefore have 34-cycle spacing.
- `hi` and `lo` are direct register outputs with no combinational path from the inputs.

## Test plan
- Multiply capture: `prod_hi = 0x00000001`, `prod_lo = 0xFFFFFFFE`, `mult_we = 1` for 1 cycle -> next cycle `hi = 0x00000001`, `lo = 0xFFFFFFFE`, `busy = 0`.
- Unsigned divide: `a = 100`, `b = 7`, `divu` -> `busy` high for 33 cycles; `done` pulse in cycle 34; `lo = 14`, `hi = 2`.
- Signed divide: `a = 0xFFFFFFF9` (-7), `b = 2`, `div` -> `lo = 0xFFFFFFFD` (-3), `hi = 0xFFFFFFFF` (-1). Also `0x80000000 / 0xFFFFFFFF` -> `lo = 0x80000000`, `hi = 0`.
- Divide by zero: `divu` with `a = 0x12345678`, `b = 0` -> `lo = 0xFFFFFFFF`, `hi = 0x12345678`, same 33-cycle latency.
- Busy lockout: during RUN, pulse `mthi` with `a = 0xDEAD`, then `div_start` -> both ignored; the final HI/LO hold the original division result, and exactly one `done` pulse occurs.
- Reset mid-op: assert `reset` at cycle 10 of a division -> `hi = lo = 0`, `busy = 0` immediately. After release, `mtlo` with `a = 5` -> `lo = 5`. Same-cycle `div_start` with `mult_we` -> the division wins and the product is dropped.

Source files
------------

// File: rtl/hilo_divider_if.sv
// Command/result bundle between the MIPS controller/ALU and the HI/LO divider block.
// The master drives operands and commands; the slave returns HI, LO and status.
interface hilo_divider_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic             mult_we;
    logic             div_start;
    logic             div_signed;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output a, b, prod_hi, prod_lo, mult_we, div_start, div_signed, mthi, mtlo,
        input  hi, lo, busy, done
    );

    modport slave (
        input  a, b, prod_hi, prod_lo, mult_we, div_start, div_signed, mthi, mtlo,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/hilo_divider.sv
// HI/LO register block with a WIDTH-cycle restoring divider (div/divu), product
// capture for mult, and mthi/mtlo moves; busy stalls the pipeline while dividing.
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    hilo_divider_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [CNT_W-1:0] count;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    // The stored remainder is always below the divisor, so WIDTH bits hold it;
    // the extra bit only exists during the shifted trial subtraction.
    always_comb begin
        a_mag     = (bus.div_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag     = (bus.div_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        rem_shift = {rem, quot[WIDTH-1]};
        trial     = rem_shift - {1'b0, divisor};
    end

    // NOTE: every register here is state, so all updates use non-blocking
    // assignments; the async reset clears operand registers too, which aborts
    // any division in flight without leaking a partial result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            divisor <= '0;
            quot    <= '0;
            rem     <= '0;
            count   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.div_start) begin
                        divisor <= b_mag;
                        quot    <= a_mag;
                        rem     <= '0;
                        count   <= '0;
                        neg_q   <= bus.div_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r   <= bus.div_signed & bus.a[WIDTH-1];
                        state   <= RUN;
                    end else if (bus.mult_we) begin
                        hi_q <= bus.prod_hi;
                        lo_q <= bus.prod_lo;
                    end else begin
                        if (bus.mthi) hi_q <= bus.a;
                        if (bus.mtlo) lo_q <= bus.a;
                    end
                end
                RUN: begin
                    if (!trial[WIDTH]) begin
                        rem  <= trial[WIDTH-1:0];
                        quot <= {quot[WIDTH-2:0], 1'b1};
                    end else begin
                        rem  <= rem_shift[WIDTH-1:0];
                        quot <= {quot[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) state <= FINISH;
                end
                FINISH: begin
                    lo_q   <= neg_q ? -quot : quot;
                    hi_q   <= neg_r ? -rem : rem;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.done = done_q;
    assign bus.busy = (state != IDLE);
endmodule
